// File: rtl/usr_ser_deframer.sv
// Serial-to-parallel deframer: assembles WIDTH-bit words from a strobed, framed
// bitstream and presents them on a one-entry valid/ready holding register.
module usr_ser_deframer #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ser_in,
    input  logic             bit_en,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    input  logic             err_clr
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_busy;
    logic             r_ovr;
    logic             r_ferr;

    state_t           w_state_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic             w_valid_nxt;
    logic             w_ovr_nxt;
    logic             w_ferr_nxt;
    logic             w_last;
    logic             w_done;
    logic             w_restart;
    logic             w_load;
    logic             w_drop;

    // Fill direction decides where the first received bit ends up after WIDTH shifts.
    generate
        if (MSB_FIRST) begin : g_msb
            assign w_shifted = {r_sreg[WIDTH-2:0], ser_in};
        end else begin : g_lsb
            assign w_shifted = {ser_in, r_sreg[WIDTH-1:1]};
        end
    endgenerate

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sreg  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sreg  <= w_sreg_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= (w_state_nxt == S_SHIFT);
            r_ovr   <= w_ovr_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sreg_nxt  = r_sreg;
        w_done      = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bit_en && frame_start) begin
                    w_sreg_nxt  = w_shifted;
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_en) begin
                    w_sreg_nxt = w_shifted;
                    if (frame_start) begin
                        // Restart: the strobed bit becomes bit 0 of the new frame.
                        w_restart = 1'b1;
                        w_cnt_nxt = CW'(1);
                    end else if (w_last) begin
                        w_done      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Holding stage: a completion may refill on the same edge the old word is taken.
    always_comb begin
        w_load      = w_done & (~r_valid | out_ready);
        w_drop      = w_done & r_valid & ~out_ready;
        w_data_nxt  = w_load ? w_shifted : r_data;
        w_valid_nxt = w_load | (r_valid & ~out_ready);
        w_ovr_nxt   = w_drop | (r_ovr & ~err_clr);
        w_ferr_nxt  = w_restart | (r_ferr & ~err_clr);
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign overrun   = r_ovr;
    assign frame_err = r_ferr;

endmodule
